// File: rtl/load_store_unit_pkg.sv
// Shared types and decode helpers for the load/store memory stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } e_lsu_op;

    // Code 0 is the idle value the cause register holds out of reset.
    typedef enum logic [1:0] {
        EXC_NONE             = 2'd0,
        EXC_MISALIGNED_LOAD  = 2'd1,
        EXC_MISALIGNED_STORE = 2'd2,
        EXC_ACCESS_FAULT     = 2'd3
    } e_lsu_exc;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } e_lsu_state;

    // Everything latched at accept time that the memory transaction needs.
    typedef struct packed {
        e_lsu_op     op;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic is_load(input e_lsu_op op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic is_store(input e_lsu_op op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic is_misaligned(input e_lsu_op op, input logic [1:0] lo);
        logic res;
        res = 1'b0;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: res = lo[0];
            LSU_LW, LSU_SW:          res = (lo != 2'b00);
            default:                 res = 1'b0;
        endcase
        return res;
    endfunction

    // Lane enables by access size; loads get the same lanes as stores of that size.
    function automatic logic [3:0] access_be(input e_lsu_op op, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: be = 4'b0001 << lo;
            LSU_LH, LSU_LHU, LSU_SH: be = 4'b0011 << lo;
            LSU_LW, LSU_SW:          be = 4'b1111;
            default:                 be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate narrow store data so every lane carries it; memory picks by byte enable.
    function automatic logic [31:0] store_wdata(input e_lsu_op op, input logic [31:0] wdata);
        logic [31:0] res;
        res = wdata;
        case (op)
            LSU_SB:  res = {4{wdata[7:0]}};
            LSU_SH:  res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data lane select and sign/zero extension.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module load_align
    import load_store_unit_pkg::*;
(
    input  e_lsu_op     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] lane;

    // Bring the addressed byte/halfword down to bit 0, then extend by op.
    always_comb begin
        lane = rdata >> {addr_lo, 3'b000};
        data = 32'h0;
        case (op)
            LSU_LB:  data = {{24{lane[7]}}, lane[7:0]};
            LSU_LBU: data = {24'h0, lane[7:0]};
            LSU_LH:  data = {{16{lane[15]}}, lane[15:0]};
            LSU_LHU: data = {16'h0, lane[15:0]};
            LSU_LW:  data = rdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: address/writeback pass-through, data memory transaction, load alignment.
// Latency: NONE/misaligned 1 cycle; memory ops 1 cycle after the response (3 minimum).
// Backpressure: in_ready low while a memory op is outstanding; request held until mem_req_ready.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  e_lsu_op     in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rsp_err,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output e_lsu_exc    exc_cause,
    output logic [31:0] exc_addr
);

    e_lsu_state  state_q, state_d;
    lsu_req_t    req_q;
    logic [31:0] wait_cnt_q;
    logic [31:0] load_data;

    logic accept;
    logic in_misaligned;
    logic start_mem;
    logic rsp_fire;
    logic timeout;

    assign accept        = in_valid && in_ready;
    assign in_misaligned = is_misaligned(in_op, in_addr[1:0]);
    assign start_mem     = accept && (in_op != LSU_NONE) && !in_misaligned;
    assign rsp_fire      = (state_q == ST_WAIT) && mem_rsp_valid;
    // Fires on the WAIT cycle whose increment would reach the limit.
    assign timeout       = (state_q == ST_WAIT) && !mem_rsp_valid && (MAX_WAIT != 0) &&
                           ((wait_cnt_q + 32'd1) == MAX_WAIT);

    // Request fields come straight from the latched request so they stay stable in REQ.
    assign mem_addr  = {req_q.addr[31:2], 2'b00};
    assign mem_we    = req_q.we;
    assign mem_be    = req_q.be;
    assign mem_wdata = req_q.wdata;

    load_align u_load_align (
        .op      (req_q.op),
        .addr_lo (req_q.addr[1:0]),
        .rdata   (mem_rdata),
        .data    (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> REQ on an aligned memory op, REQ -> WAIT on handshake, WAIT -> IDLE on response or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_mem)           state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)       state_d = ST_WAIT;
            ST_WAIT: if (rsp_fire || timeout) state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        in_ready      = (state_q == ST_IDLE);
        mem_req_valid = (state_q == ST_REQ);
    end

    // Capture the request on accept; formatted store data and lane enables are precomputed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (start_mem) begin
            req_q.op    <= in_op;
            req_q.addr  <= in_addr;
            req_q.rd    <= in_rd;
            req_q.we    <= is_store(in_op);
            req_q.be    <= access_be(in_op, in_addr[1:0]);
            req_q.wdata <= store_wdata(in_op, in_wdata);
        end
    end

    // Wait watchdog: cleared while requesting, counts WAIT cycles without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 32'd0;
        end else if (state_q == ST_REQ) begin
            wait_cnt_q <= 32'd0;
        end else if ((state_q == ST_WAIT) && !mem_rsp_valid) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    // Registered retire/exception; valids pulse for one cycle, data fields hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'h0;
            exc_valid <= 1'b0;
            exc_cause <= EXC_NONE;
            exc_addr  <= 32'h0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            if (accept && (in_op == LSU_NONE)) begin
                wb_valid <= 1'b1;
                wb_we    <= (in_rd != 5'd0);
                wb_rd    <= in_rd;
                wb_data  <= in_addr;
            end else if (accept && in_misaligned) begin
                exc_valid <= 1'b1;
                exc_cause <= is_store(in_op) ? EXC_MISALIGNED_STORE : EXC_MISALIGNED_LOAD;
                exc_addr  <= in_addr;
            end else if (rsp_fire && mem_rsp_err) begin
                exc_valid <= 1'b1;
                exc_cause <= EXC_ACCESS_FAULT;
                exc_addr  <= req_q.addr;
            end else if (rsp_fire) begin
                wb_valid <= 1'b1;
                wb_rd    <= req_q.rd;
                if (is_load(req_q.op)) begin
                    wb_we   <= (req_q.rd != 5'd0);
                    wb_data <= load_data;
                end else begin
                    wb_we   <= 1'b0;
                    wb_data <= 32'h0;
                end
            end else if (timeout) begin
                exc_valid <= 1'b1;
                exc_cause <= EXC_ACCESS_FAULT;
                exc_addr  <= req_q.addr;
            end
        end
    end

endmodule
